// File: rtl/toggle_link_pkg.sv
// Shared types and default sizing for the toggle-encoded event link.
package toggle_link_pkg;

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_PEND  = 2'd1,
        S_FULL  = 2'd2
    } state_t;

    localparam int DEF_SYNC_STAGES = 2;
    localparam int DEF_CNT_W       = 4;

endpackage

// File: rtl/toggle_event_rx_if.sv
// Valid/ready event interface carrying the pending-event count alongside.
interface toggle_event_rx_if
    import toggle_link_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W
);
    logic             evt_valid;
    logic             evt_ready;
    logic [CNT_W-1:0] evt_count;

    modport master (output evt_valid, output evt_count, input evt_ready);
    modport slave  (input evt_valid, input evt_count, output evt_ready);

endinterface

// File: rtl/toggle_sync_edge.sv
// Synchronizes the async toggle level and emits a registered one-cycle pulse per level change.
module toggle_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic tog_in,
    output logic evt_edge
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   tog_s;
    logic                   tog_prev;
    logic                   primed;
    logic [2:0]             prime_cnt;

    assign tog_s = sync_q[SYNC_STAGES-1];

    // primed waits until the reset-cleared chain has flushed, so a level held
    // through reset release reaches tog_prev without being seen as an edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q    <= '0;
            tog_prev  <= 1'b0;
            primed    <= 1'b0;
            prime_cnt <= 3'(SYNC_STAGES);
            evt_edge  <= 1'b0;
        end else begin
            sync_q   <= {sync_q[SYNC_STAGES-2:0], tog_in};
            tog_prev <= tog_s;
            evt_edge <= primed & (tog_s ^ tog_prev);
            if (prime_cnt != 3'd0) begin
                prime_cnt <= prime_cnt - 3'd1;
            end
            primed <= (prime_cnt == 3'd0);
        end
    end

endmodule

// File: rtl/toggle_event_rx.sv
// Receive end of the toggle event link: counts recovered events, hands them out
// over valid/ready and toggles ack_tog once per consumed event.
//   state   | meaning
//   S_EMPTY | no events pending (count 0)
//   S_PEND  | 0 < count < MAX
//   S_FULL  | count at MAX, further edges are dropped and flagged
module toggle_event_rx
    import toggle_link_pkg::*;
#(
    parameter int SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int CNT_W       = DEF_CNT_W
) (
    input  logic clk,
    input  logic rst,
    input  logic tog_in,
    input  logic clr_ovf,
    output logic ack_tog,
    output logic overflow,
    toggle_event_rx_if.master evt
);

    localparam logic [CNT_W-1:0] MAX = '1;
    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    state_t           state;
    logic [CNT_W-1:0] count;
    logic             valid;
    logic             evt_edge;
    logic             pop;

    toggle_sync_edge #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk      (clk),
        .rst      (rst),
        .tog_in   (tog_in),
        .evt_edge (evt_edge)
    );

    assign pop           = valid & evt.evt_ready;
    assign evt.evt_valid = valid;
    assign evt.evt_count = count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_EMPTY;
            count    <= '0;
            valid    <= 1'b0;
            ack_tog  <= 1'b0;
            overflow <= 1'b0;
        end else begin
            if (pop) begin
                ack_tog <= ~ack_tog;
            end

            // A drop in the same cycle as clr_ovf must still be reported.
            if (state == S_FULL && evt_edge && !pop) begin
                overflow <= 1'b1;
            end else if (clr_ovf) begin
                overflow <= 1'b0;
            end

            case (state)
                S_EMPTY: begin
                    if (evt_edge) begin
                        count <= count + ONE;
                        valid <= 1'b1;
                        state <= (MAX == ONE) ? S_FULL : S_PEND;
                    end
                end
                S_PEND: begin
                    if (evt_edge && !pop) begin
                        count <= count + ONE;
                        if (count == MAX - ONE) begin
                            state <= S_FULL;
                        end
                    end else if (pop && !evt_edge) begin
                        count <= count - ONE;
                        if (count == ONE) begin
                            state <= S_EMPTY;
                            valid <= 1'b0;
                        end
                    end
                end
                S_FULL: begin
                    if (pop && !evt_edge) begin
                        count <= count - ONE;
                        state <= (count == ONE) ? S_EMPTY : S_PEND;
                        valid <= (count != ONE);
                    end
                end
                default: begin
                    state <= S_EMPTY;
                    count <= '0;
                    valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_toggle_event_rx.sv
// Scoreboard bench for toggle_event_rx: each sent flip queues an event, each observed pop retires one.
module tb_toggle_event_rx;
    import toggle_link_pkg::*;

    localparam int SYNC_STAGES = 2;
    localparam int CNT_W       = 4;
    localparam int MAXC        = 15;

    logic clk     = 1'b0;
    logic rst     = 1'b1;
    logic tog_in  = 1'b1;
    logic clr_ovf = 1'b0;
    logic ack_tog;
    logic overflow;

    toggle_event_rx_if #(.CNT_W(CNT_W)) evt ();

    toggle_event_rx #(
        .SYNC_STAGES(SYNC_STAGES),
        .CNT_W      (CNT_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .tog_in   (tog_in),
        .clr_ovf  (clr_ovf),
        .ack_tog  (ack_tog),
        .overflow (overflow),
        .evt      (evt)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int sb_q[$];
    int evt_id = 0;
    logic exp_ack = 1'b0;
    logic exp_ovf = 1'b0;
    logic [CNT_W-1:0] exp_cnt;

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic flip();
        tog_in = ~tog_in;
        if (sb_q.size() < MAXC) sb_q.push_back(evt_id);
        else exp_ovf = 1'b1;
        evt_id++;
    endtask

    task automatic test_reset();
        evt.evt_ready = 1'b0;
        tick(3);
        n_cmp++;
        if (evt.evt_valid !== 1'b0 || evt.evt_count !== '0 || ack_tog !== 1'b0 ||
            overflow !== 1'b0 || dut.state !== S_EMPTY) begin
            n_err++;
            $display("FAIL reset_state: valid=%b count=%0d ack=%b ovf=%b state=%0d, required all 0/S_EMPTY",
                     evt.evt_valid, evt.evt_count, ack_tog, overflow, dut.state);
        end
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            n_cmp++;
            if (evt.evt_valid !== 1'b0 || evt.evt_count !== '0) begin
                n_err++;
                $display("FAIL static_high_absorbed cyc %0d: valid=%b count=%0d, required 0/0",
                         i, evt.evt_valid, evt.evt_count);
            end
        end
    endtask

    task automatic test_count_three();
        flip();
        for (int k = 1; k <= SYNC_STAGES + 2; k++) begin
            tick();
            n_cmp++;
            if (evt.evt_valid !== (k == SYNC_STAGES + 2)) begin
                n_err++;
                $display("FAIL first_valid_latency edge %0d: valid=%b, required %b",
                         k, evt.evt_valid, (k == SYNC_STAGES + 2));
            end
        end
        tick(5 - (SYNC_STAGES + 2));
        flip();
        tick(5);
        flip();
        tick(6);
        exp_cnt = CNT_W'(sb_q.size());
        n_cmp++;
        if (evt.evt_count !== exp_cnt || exp_cnt !== CNT_W'(3) || evt.evt_valid !== 1'b1) begin
            n_err++;
            $display("FAIL count_three: count=%0d valid=%b, required %0d/1", evt.evt_count, evt.evt_valid, exp_cnt);
        end
    endtask

    task automatic test_drain(input int n_pops, input int budget);
        int pops;
        int ticks;
        logic v;
        pops = 0;
        ticks = 0;
        evt.evt_ready = 1'b1;
        while (pops < n_pops && ticks < budget) begin
            v = evt.evt_valid;
            tick();
            ticks++;
            if (v) begin
                pops++;
                void'(sb_q.pop_front());
                exp_ack = ~exp_ack;
                n_cmp++;
                if (ack_tog !== exp_ack) begin
                    n_err++;
                    $display("FAIL ack_per_pop %0d: ack=%b, required %b", pops, ack_tog, exp_ack);
                end
            end
        end
        evt.evt_ready = 1'b0;
        n_cmp++;
        if (pops != n_pops || ticks != n_pops) begin
            n_err++;
            $display("FAIL drain_consecutive: pops=%0d in %0d cycles, required %0d in %0d", pops, ticks, n_pops, n_pops);
        end
        exp_cnt = CNT_W'(sb_q.size());
        n_cmp++;
        if (evt.evt_count !== exp_cnt || evt.evt_valid !== (exp_cnt != '0)) begin
            n_err++;
            $display("FAIL drain_count: count=%0d valid=%b, required %0d/%b",
                     evt.evt_count, evt.evt_valid, exp_cnt, (exp_cnt != '0));
        end
    endtask

    task automatic test_overflow();
        for (int i = 0; i < MAXC; i++) begin
            flip();
            tick(3);
        end
        tick(3);
        n_cmp++;
        if (evt.evt_count !== CNT_W'(MAXC) || overflow !== 1'b0 || dut.state !== S_FULL) begin
            n_err++;
            $display("FAIL fill_to_max: count=%0d ovf=%b state=%0d, required 15/0/S_FULL",
                     evt.evt_count, overflow, dut.state);
        end
        flip();
        tick(6);
        n_cmp++;
        if (evt.evt_count !== CNT_W'(MAXC) || overflow !== exp_ovf || exp_ovf !== 1'b1 || dut.state !== S_FULL) begin
            n_err++;
            $display("FAIL drop_at_max: count=%0d ovf=%b state=%0d, required 15/1/S_FULL",
                     evt.evt_count, overflow, dut.state);
        end
        clr_ovf = 1'b1;
        tick();
        clr_ovf = 1'b0;
        exp_ovf = 1'b0;
        n_cmp++;
        if (overflow !== exp_ovf || evt.evt_count !== CNT_W'(MAXC)) begin
            n_err++;
            $display("FAIL clr_ovf: ovf=%b count=%0d, required 0/15", overflow, evt.evt_count);
        end
    endtask

    task automatic test_full_coincident();
        // edge lands on the clock after SYNC_STAGES+1 edges; pop exactly then
        tog_in = ~tog_in;
        tick(SYNC_STAGES + 1);
        evt.evt_ready = 1'b1;
        tick();
        evt.evt_ready = 1'b0;
        void'(sb_q.pop_front());
        sb_q.push_back(evt_id);
        evt_id++;
        exp_ack = ~exp_ack;
        tick(3);
        n_cmp++;
        if (evt.evt_count !== CNT_W'(sb_q.size()) || overflow !== 1'b0 || ack_tog !== exp_ack) begin
            n_err++;
            $display("FAIL edge_and_pop_at_max: count=%0d ovf=%b ack=%b, required %0d/0/%b",
                     evt.evt_count, overflow, ack_tog, sb_q.size(), exp_ack);
        end
        tog_in = ~tog_in;
        evt_id++;
        tick(SYNC_STAGES + 1);
        clr_ovf = 1'b1;
        tick();
        clr_ovf = 1'b0;
        exp_ovf = 1'b1;
        n_cmp++;
        if (overflow !== exp_ovf || evt.evt_count !== CNT_W'(MAXC)) begin
            n_err++;
            $display("FAIL set_beats_clear: ovf=%b count=%0d, required 1/15", overflow, evt.evt_count);
        end
        clr_ovf = 1'b1;
        tick();
        clr_ovf = 1'b0;
        exp_ovf = 1'b0;
    endtask

    task automatic test_async_reset();
        test_drain(10, 20);
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        sb_q.delete();
        exp_ack = 1'b0;
        exp_ovf = 1'b0;
        n_cmp++;
        if (evt.evt_valid !== 1'b0 || evt.evt_count !== '0 || ack_tog !== exp_ack || overflow !== exp_ovf) begin
            n_err++;
            $display("FAIL async_reset: valid=%b count=%0d ack=%b ovf=%b, required all 0",
                     evt.evt_valid, evt.evt_count, ack_tog, overflow);
        end
        tick();
        rst = 1'b0;
        tick(10);
        n_cmp++;
        if (evt.evt_count !== '0 || evt.evt_valid !== 1'b0) begin
            n_err++;
            $display("FAIL post_reset_idle: count=%0d valid=%b, required 0/0", evt.evt_count, evt.evt_valid);
        end
        flip();
        tick(5);
        flip();
        tick(6);
        exp_cnt = CNT_W'(sb_q.size());
        n_cmp++;
        if (evt.evt_count !== exp_cnt || exp_cnt !== CNT_W'(2) || evt.evt_valid !== 1'b1) begin
            n_err++;
            $display("FAIL post_reset_count: count=%0d valid=%b, required %0d/1", evt.evt_count, evt.evt_valid, exp_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_count_three();
        test_drain(3, 10);
        test_overflow();
        test_full_coincident();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
